// File: rtl/config_frame_loader.sv
// Configuration frame loader: a sync word opens a session, headers select the frame address and word count, and data words are emitted as frames.
// Optional session idle timeout is enabled by defining CONFIG_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no session; only SYNC_WORD is accepted
// HEADER | session open; waiting for a command word
// DATA   | emitting frames until the word counter reaches zero
module config_frame_loader #(
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
    parameter int          ADDR_WIDTH     = 8,
    parameter int          TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  word_write_strobe_i,
    input  logic [31:0]           write_data_i,
    output logic                  frame_valid_o,
    output logic [ADDR_WIDTH-1:0] frame_addr_o,
    output logic [31:0]           frame_data_o,
    output logic                  config_active_o,
    output logic                  config_done_o,
    output logic                  error_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            count_q;

    logic [7:0]            hdr_cmd;
    logic [ADDR_WIDTH-1:0] hdr_addr;
    logic [7:0]            hdr_count;
    logic                  is_sync;

    assign hdr_cmd   = write_data_i[31:24];
    assign hdr_addr  = write_data_i[ADDR_WIDTH+7:8];
    assign hdr_count = write_data_i[7:0];
    assign is_sync   = (write_data_i == SYNC_WORD);

`ifdef CONFIG_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    // Down-counter reloaded on every strobe; expiry is the idle cycle seen at zero.
    logic [TW-1:0] timer_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= ST_IDLE;
            addr_q          <= '0;
            count_q         <= '0;
            frame_valid_o   <= 1'b0;
            frame_addr_o    <= '0;
            frame_data_o    <= '0;
            config_active_o <= 1'b0;
            config_done_o   <= 1'b0;
            error_o         <= 1'b0;
`ifdef CONFIG_TIMEOUT_EN
            timer_q         <= '0;
`endif
        end else begin
            frame_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (word_write_strobe_i && is_sync) begin
                        state           <= ST_HEADER;
                        config_active_o <= 1'b1;
                        config_done_o   <= 1'b0;
                        error_o         <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    // A repeated sync word inside a session is a harmless no-op.
                    if (word_write_strobe_i && !is_sync) begin
                        case (hdr_cmd)
                            8'h01: begin
                                if (hdr_count != 8'd0) begin
                                    addr_q  <= hdr_addr;
                                    count_q <= hdr_count;
                                    state   <= ST_DATA;
                                end
                            end
                            8'h00: begin
                                config_done_o   <= 1'b1;
                                config_active_o <= 1'b0;
                                state           <= ST_IDLE;
                            end
                            default: begin
                                error_o         <= 1'b1;
                                config_active_o <= 1'b0;
                                state           <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_DATA: begin
                    if (word_write_strobe_i) begin
                        frame_valid_o <= 1'b1;
                        frame_addr_o  <= addr_q;
                        frame_data_o  <= write_data_i;
                        addr_q        <= addr_q + ADDR_WIDTH'(1);
                        count_q       <= count_q - 8'd1;
                        if (count_q == 8'd1) begin
                            state <= ST_HEADER;
                        end
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    config_active_o <= 1'b0;
                end
            endcase
`ifdef CONFIG_TIMEOUT_EN
            if (word_write_strobe_i) begin
                timer_q <= TIMER_LOAD;
            end else if (state != ST_IDLE) begin
                if (timer_q == '0) begin
                    error_o         <= 1'b1;
                    config_active_o <= 1'b0;
                    state           <= ST_IDLE;
                end else begin
                    timer_q <= timer_q - TW'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed-vector bench for config_frame_loader; the timeout scenario runs when CONFIG_TIMEOUT_EN is defined.
module tb_config_frame_loader;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        word_write_strobe_i;
    logic [31:0] write_data_i;
    logic        frame_valid_o;
    logic [7:0]  frame_addr_o;
    logic [31:0] frame_data_o;
    logic        config_active_o;
    logic        config_done_o;
    logic        error_o;

    int n_cmp = 0;
    int n_err = 0;

    config_frame_loader #(
        .SYNC_WORD      (SYNC),
        .ADDR_WIDTH     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .word_write_strobe_i (word_write_strobe_i),
        .write_data_i        (write_data_i),
        .frame_valid_o       (frame_valid_o),
        .frame_addr_o        (frame_addr_o),
        .frame_data_o        (frame_data_o),
        .config_active_o     (config_active_o),
        .config_done_o       (config_done_o),
        .error_o             (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Strobe one word; return just after the edge that consumes it.
    task automatic put(input logic [31:0] w);
        @(negedge clk_i);
        word_write_strobe_i = 1'b1;
        write_data_i        = w;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            word_write_strobe_i = 1'b0;
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic put_frame(input string tag, input logic [31:0] w, input logic [7:0] exp_addr);
        put(w);
        chk({tag, "_valid"}, 32'(frame_valid_o), 32'd1);
        chk({tag, "_addr"}, 32'(frame_addr_o), 32'(exp_addr));
        chk({tag, "_data"}, frame_data_o, w);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},  32'(frame_valid_o),   32'd0);
        chk({tag, "_addr"},   32'(frame_addr_o),    32'd0);
        chk({tag, "_data"},   frame_data_o,         32'd0);
        chk({tag, "_active"}, 32'(config_active_o), 32'd0);
        chk({tag, "_done"},   32'(config_done_o),   32'd0);
        chk({tag, "_error"},  32'(error_o),         32'd0);
    endtask

    initial begin
        reset_i             = 1'b1;
        word_write_strobe_i = 1'b0;
        write_data_i        = '0;
        idle(3);
        chk_reset_outputs("rst");
        @(negedge clk_i);
        reset_i = 1'b0;

        // Basic burst: three frames at 0x10..0x12, then back in HEADER.
        put(SYNC);
        chk("t1_active", 32'(config_active_o), 32'd1);
        put(32'h0105_1003);
        chk("t1_hdr_valid", 32'(frame_valid_o), 32'd0);
        put_frame("t1_a0", 32'h0000_00A0, 8'h10);
        put_frame("t1_a1", 32'h0000_00A1, 8'h11);
        put_frame("t1_a2", 32'h0000_00A2, 8'h12);
        idle(1);
        chk("t1_pulse_end", 32'(frame_valid_o), 32'd0);
        chk("t1_hold_addr", 32'(frame_addr_o), 32'h12);
        chk("t1_hold_data", frame_data_o, 32'hA2);
        chk("t1_in_header", 32'(config_active_o), 32'd1);
        put(32'h0000_00A3);
        chk("t1_end_done", 32'(config_done_o), 32'd1);
        chk("t1_end_active", 32'(config_active_o), 32'd0);

        // Address run to 0xFF, then wrap to 0x00; count=0 header is a no-op.
        put(SYNC);
        chk("t2_done_clr", 32'(config_done_o), 32'd0);
        put(32'h0101_FE02);
        put_frame("t2_d0", 32'h0000_00D0, 8'hFE);
        put_frame("t2_d1", 32'h0000_00D1, 8'hFF);
        put(32'h0101_FF02);
        put_frame("t2_e0", 32'h0000_00E0, 8'hFF);
        put_frame("t2_e1", 32'h0000_00E1, 8'h00);
        put(32'h0101_2000);
        chk("t2_cnt0_valid", 32'(frame_valid_o), 32'd0);
        chk("t2_cnt0_active", 32'(config_active_o), 32'd1);
        put(32'h0101_2001);
        put_frame("t2_after_cnt0", 32'h0000_00F0, 8'h20);

        // Unknown command is a sticky error, cleared by the next sync.
        put(32'h0700_0000);
        chk("t3_err", 32'(error_o), 32'd1);
        chk("t3_active", 32'(config_active_o), 32'd0);
        put(32'h0000_00A5);
        idle(2);
        chk("t3_err_sticky", 32'(error_o), 32'd1);
        put(SYNC);
        chk("t3_err_clr", 32'(error_o), 32'd0);
        chk("t3_active2", 32'(config_active_o), 32'd1);

        // Sync in HEADER is ignored; sync in DATA is ordinary data.
        put(SYNC);
        chk("t4_hdr_sync_active", 32'(config_active_o), 32'd1);
        chk("t4_hdr_sync_err", 32'(error_o), 32'd0);
        put(32'h0101_0002);
        put_frame("t4_sync_data", SYNC, 8'h00);
        put_frame("t4_55", 32'h0000_0055, 8'h01);
        put(32'h0000_0000);
        chk("t4_done", 32'(config_done_o), 32'd1);
        chk("t4_active", 32'(config_active_o), 32'd0);

        // Reset mid-DATA with a strobe present abandons the session.
        put(SYNC);
        put(32'h0101_3004);
        put_frame("t5_b0", 32'h0000_00B0, 8'h30);
        @(negedge clk_i);
        reset_i             = 1'b1;
        word_write_strobe_i = 1'b1;
        write_data_i        = 32'h0000_00B1;
        @(posedge clk_i);
        #1;
        chk_reset_outputs("t5_rst");
        @(negedge clk_i);
        reset_i = 1'b0;
        put(32'h0000_00B2);
        chk("t5_b2_valid", 32'(frame_valid_o), 32'd0);
        put(32'h0000_00B3);
        chk("t5_b3_valid", 32'(frame_valid_o), 32'd0);
        idle(1);
        chk_reset_outputs("t5_post");

`ifdef CONFIG_TIMEOUT_EN
        put(SYNC);
        idle(15);
        chk("t6_15_err", 32'(error_o), 32'd0);
        chk("t6_15_active", 32'(config_active_o), 32'd1);
        idle(1);
        chk("t6_16_err", 32'(error_o), 32'd1);
        chk("t6_16_active", 32'(config_active_o), 32'd0);
        put(SYNC);
        idle(15);
        put(32'h0101_4001);
        chk("t6_hdr_err", 32'(error_o), 32'd0);
        chk("t6_hdr_active", 32'(config_active_o), 32'd1);
        put_frame("t6_frame", 32'h0000_00C0, 8'h40);
`else
        put(SYNC);
        idle(200);
        chk("t6_wait_err", 32'(error_o), 32'd0);
        chk("t6_wait_active", 32'(config_active_o), 32'd1);
        put(32'h0101_4001);
        put_frame("t6_frame", 32'h0000_00C0, 8'h40);
`endif
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
